// File: rtl/fp_ctrl_pkg.sv
// ==========================================================================
// fp_ctrl_pkg: shared encodings for the FMA sequencer (ops, rounding modes,
// fflags positions, canonical NaNs, controller states).    Rev 1.0
// ==========================================================================
`default_nettype none

package fp_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_FMADD  = 2'b00,
    OP_FMSUB  = 2'b01,
    OP_FNMSUB = 2'b10,
    OP_FNMADD = 2'b11
  } fma_op_e;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;
  localparam logic [2:0] RM_DYN = 3'b111;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam logic [31:0] QNAN32 = 32'h7FC0_0000;
  localparam logic [63:0] QNAN64 = 64'h7FF8_0000_0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_RESP   = 3'd3,
    ST_DRAIN  = 3'd4
  } ctrl_state_e;

  // Only the five static modes may reach the unit; 101/110/111 are reserved.
  function automatic logic rm_legal(input logic [2:0] rm);
    return (rm <= RM_RMM);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_rr_arb2.sv
// ==========================================================================
// fp_rr_arb2: two-requester round-robin arbiter; pointer moves to the
// non-granted port on every accept.                         Rev 1.0
// ==========================================================================
`default_nettype none

module fp_rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o,
  output logic       gnt_idx_o,
  output logic       accept_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_idx_o = ptr_q;
    if (!req_i[ptr_q]) gnt_idx_o = ~ptr_q;
    accept_o = en_i & (|req_i);
    gnt_o    = 2'b00;
    if (en_i) gnt_o[gnt_idx_o] = req_i[gnt_idx_o];
    ptr_d = accept_o ? ~gnt_idx_o : ptr_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= 1'b0;
    else          ptr_q <= ptr_d;
  end

endmodule

`default_nettype wire

// File: rtl/fp_fma_ctrl.sv
// ==========================================================================
// fp_fma_ctrl: two-port sequencer for the multi-cycle FMA unit with flush,
// timeout and tagged valid/ready response.                  Rev 1.0
// ==========================================================================
`default_nettype none

module fp_fma_ctrl
  import fp_ctrl_pkg::*;
#(
  parameter int FLEN    = 32,
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [2:0]       req0_rm,
  input  logic [FLEN-1:0]  req0_a,
  input  logic [FLEN-1:0]  req0_b,
  input  logic [FLEN-1:0]  req0_c,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [2:0]       req1_rm,
  input  logic [FLEN-1:0]  req1_a,
  input  logic [FLEN-1:0]  req1_b,
  input  logic [FLEN-1:0]  req1_c,
  input  logic [TAG_W-1:0] req1_tag,
  input  logic [2:0]       frm,
  input  logic             flush,
  output logic             fma_start,
  output logic [1:0]       fma_op,
  output logic [2:0]       fma_rm,
  output logic [FLEN-1:0]  fma_a,
  output logic [FLEN-1:0]  fma_b,
  output logic [FLEN-1:0]  fma_c,
  input  logic             fma_done,
  input  logic [FLEN-1:0]  fma_result,
  input  logic             fma_nv,
  input  logic             fma_of,
  input  logic             fma_uf,
  input  logic             fma_nx,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_src,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [FLEN-1:0]  rsp_result,
  output logic [4:0]       rsp_flags,
  output logic             rsp_illegal,
  output logic             rsp_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [FLEN-1:0] C_QNAN = (FLEN == 64) ? FLEN'(QNAN64) : FLEN'(QNAN32);

  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       gnt;
  logic             sel, accept, arb_en, to_hit;
  logic             ld, cap_done, cap_to;
  logic [2:0]       w_rm, eff_rm;
  logic [4:0]       w_done_flags;

  logic [1:0]       op_q;
  logic [2:0]       rm_q;
  logic [FLEN-1:0]  a_q, b_q, c_q, res_q;
  logic [TAG_W-1:0] tag_q;
  logic             src_q, ill_q, tmo_q;
  logic [4:0]       flg_q;

  assign arb_en = (state_q == ST_IDLE) && !flush;

  fp_rr_arb2 u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_i     ({req1_valid, req0_valid}),
    .en_i      (arb_en),
    .gnt_o     (gnt),
    .gnt_idx_o (sel),
    .accept_o  (accept)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  assign w_rm   = sel ? req1_rm : req0_rm;
  assign eff_rm = (w_rm == RM_DYN) ? frm : w_rm;
  // Counter holds cycles elapsed since the start pulse; abort lands the
  // response exactly TIMEOUT cycles after start.
  assign to_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    w_done_flags          = 5'b00000;
    w_done_flags[FLAG_NV] = fma_nv;
    w_done_flags[FLAG_OF] = fma_of;
    w_done_flags[FLAG_UF] = fma_uf;
    w_done_flags[FLAG_NX] = fma_nx;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fma_start = 1'b0;
    rsp_valid = 1'b0;
    ld        = 1'b0;
    cap_done  = 1'b0;
    cap_to    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ld      = 1'b1;
          state_d = rm_legal(eff_rm) ? ST_LAUNCH : ST_RESP;
        end
      end
      ST_LAUNCH: begin
        fma_start = 1'b1;
        cnt_d     = CNT_W'(1);
        state_d   = flush ? ST_DRAIN : ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // If the unit already finished this cycle there is nothing left to drain.
        if (flush)         state_d = (fma_done || to_hit) ? ST_IDLE : ST_DRAIN;
        else if (fma_done) begin cap_done = 1'b1; state_d = ST_RESP; end
        else if (to_hit)   begin cap_to   = 1'b1; state_d = ST_RESP; end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (flush || rsp_ready) state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (fma_done || to_hit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      rm_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      tag_q   <= '0;
      src_q   <= 1'b0;
      res_q   <= '0;
      flg_q   <= '0;
      ill_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (ld) begin
        op_q  <= sel ? req1_op  : req0_op;
        rm_q  <= eff_rm;
        a_q   <= sel ? req1_a   : req0_a;
        b_q   <= sel ? req1_b   : req0_b;
        c_q   <= sel ? req1_c   : req0_c;
        tag_q <= sel ? req1_tag : req0_tag;
        src_q <= sel;
        res_q <= '0;
        flg_q <= '0;
        ill_q <= !rm_legal(eff_rm);
        tmo_q <= 1'b0;
      end
      if (cap_done) begin
        res_q <= fma_result;
        flg_q <= w_done_flags;
      end
      if (cap_to) begin
        res_q          <= C_QNAN;
        flg_q          <= 5'b00000;
        flg_q[FLAG_NV] <= 1'b1;
        tmo_q          <= 1'b1;
      end
    end
  end

  assign fma_op      = op_q;
  assign fma_rm      = rm_q;
  assign fma_a       = a_q;
  assign fma_b       = b_q;
  assign fma_c       = c_q;
  assign rsp_src     = src_q;
  assign rsp_tag     = tag_q;
  assign rsp_result  = res_q;
  assign rsp_flags   = flg_q;
  assign rsp_illegal = ill_q;
  assign rsp_timeout = tmo_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_fma_ctrl.sv
// ==========================================================================
// tb_fp_fma_ctrl: directed vector table plus hand-written sequences for
// arbitration, flush/drain, timeout, response stall and reset.  Rev 1.0
// ==========================================================================
`default_nettype none

module tb_fp_fma_ctrl;

  localparam int FLEN    = 32;
  localparam int TAG_W   = 5;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic reset_n;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0] req0_op, req1_op;
  logic [2:0] req0_rm, req1_rm, frm;
  logic [31:0] req0_a, req0_b, req0_c, req1_a, req1_b, req1_c;
  logic [4:0] req0_tag, req1_tag;
  logic flush;
  logic fma_start;
  logic [1:0] fma_op;
  logic [2:0] fma_rm;
  logic [31:0] fma_a, fma_b, fma_c;
  logic fma_done;
  logic [31:0] fma_result;
  logic fma_nv, fma_of, fma_uf, fma_nx;
  logic rsp_valid, rsp_ready, rsp_src;
  logic [4:0] rsp_tag;
  logic [31:0] rsp_result;
  logic [4:0] rsp_flags;
  logic rsp_illegal, rsp_timeout;

  always #5 clk = ~clk;

  fp_fma_ctrl #(.FLEN(FLEN), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_rm(req0_rm),
    .req0_a(req0_a), .req0_b(req0_b), .req0_c(req0_c), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_rm(req1_rm),
    .req1_a(req1_a), .req1_b(req1_b), .req1_c(req1_c), .req1_tag(req1_tag),
    .frm(frm), .flush(flush),
    .fma_start(fma_start), .fma_op(fma_op), .fma_rm(fma_rm),
    .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c),
    .fma_done(fma_done), .fma_result(fma_result),
    .fma_nv(fma_nv), .fma_of(fma_of), .fma_uf(fma_uf), .fma_nx(fma_nx),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_src(rsp_src), .rsp_tag(rsp_tag),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .rsp_illegal(rsp_illegal), .rsp_timeout(rsp_timeout)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural FMA: done pulses model_lat cycles after the start pulse.
  int          model_lat = 6;
  bit          model_en  = 1'b1;
  logic [31:0] model_res = 32'h0;
  logic [3:0]  model_flg = 4'h0;
  int          spur_cnt  = 0;

  initial begin : fma_model
    int cd;
    int spur_seen;
    cd = 0;
    spur_seen = 0;
    fma_done = 1'b0;
    fma_result = 32'h0;
    {fma_nv, fma_of, fma_uf, fma_nx} = 4'h0;
    forever begin
      @(posedge clk);
      #1;
      fma_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          fma_done = 1'b1;
          fma_result = model_res;
          {fma_nv, fma_of, fma_uf, fma_nx} = model_flg;
        end
      end
      if (spur_cnt != spur_seen) begin
        spur_seen = spur_cnt;
        fma_done = 1'b1;
        fma_result = 32'hDEADBEEF;
        {fma_nv, fma_of, fma_uf, fma_nx} = 4'hF;
      end
      if (fma_start && model_en) cd = model_lat;
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    bit          port;
    logic [1:0]  op;
    logic [2:0]  rm;
    logic [2:0]  frm;
    logic [31:0] a, b, c;
    logic [4:0]  tag;
    logic [31:0] mres;
    logic [3:0]  mflg;
    logic [31:0] eres;
    logic [4:0]  eflg;
    bit          ill;
    logic [2:0]  erm;
    int          elat;
  } vec_t;

  vec_t vt[8];

  task automatic set_req(input bit p, input logic v, input logic [1:0] op, input logic [2:0] rm,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [4:0] tag);
    if (p) begin
      req1_valid = v; req1_op = op; req1_rm = rm; req1_a = a; req1_b = b; req1_c = c; req1_tag = tag;
    end else begin
      req0_valid = v; req0_op = op; req0_rm = rm; req0_a = a; req0_b = b; req0_c = c; req0_tag = tag;
    end
  endtask

  // Called at a negedge after set_req; returns at the first negedge after the accept edge.
  task automatic wait_accept(input bit p, input string nm);
    bit ok;
    ok = 1'b0;
    #1;
    for (int i = 0; i < 40; i++) begin
      if ((p ? req1_ready : req0_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (!ok) chk({nm, "_accept"}, 64'(0), 64'(1));
    @(posedge clk);
    @(negedge clk);
    if (p) req1_valid = 1'b0;
    else   req0_valid = 1'b0;
  endtask

  task automatic drain_rsp(input string nm);
    for (int i = 0; i < 40 && rsp_valid !== 1'b1; i++) @(negedge clk);
    chk({nm, "_rsp"}, 64'(rsp_valid), 64'(1));
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_ready0"},  64'(req0_ready), 64'(0));
    chk({nm, "_ready1"},  64'(req1_ready), 64'(0));
    chk({nm, "_start"},   64'(fma_start),  64'(0));
    chk({nm, "_fma_a"},   64'(fma_a),      64'(0));
    chk({nm, "_fma_rm"},  64'(fma_rm),     64'(0));
    chk({nm, "_fma_op"},  64'(fma_op),     64'(0));
    chk({nm, "_rvalid"},  64'(rsp_valid),  64'(0));
    chk({nm, "_rresult"}, 64'(rsp_result), 64'(0));
    chk({nm, "_rtag"},    64'(rsp_tag),    64'(0));
    chk({nm, "_rflags"},  64'(rsp_flags),  64'(0));
  endtask

  int n;
  int k, rk;
  bit g[4];
  bit rs[4];
  vec_t v;

  initial begin : main
    reset_n = 1'b0;
    frm = 3'b000;
    flush = 1'b0;
    rsp_ready = 1'b1;
    set_req(1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0);
    set_req(1'b1, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0);

    vt[0] = '{1'b0, 2'b00, 3'b000, 3'b000, 32'h3F800000, 32'h40000000, 32'h40400000, 5'd7,
              32'h40A00000, 4'b0000, 32'h40A00000, 5'b00000, 1'b0, 3'b000, 8};
    vt[1] = '{1'b1, 2'b01, 3'b001, 3'b000, 32'h40000000, 32'h40400000, 32'h40000000, 5'd3,
              32'h40800000, 4'b0001, 32'h40800000, 5'b00001, 1'b0, 3'b001, 8};
    vt[2] = '{1'b0, 2'b10, 3'b111, 3'b010, 32'h3F800000, 32'h3F800000, 32'h40000000, 5'd31,
              32'h3F800000, 4'b0101, 32'h3F800000, 5'b00101, 1'b0, 3'b010, 8};
    vt[3] = '{1'b0, 2'b00, 3'b111, 3'b101, 32'h3F800000, 32'h3F800000, 32'h3F800000, 5'd9,
              32'h12345678, 4'b0000, 32'h00000000, 5'b00000, 1'b1, 3'b101, 1};
    vt[4] = '{1'b1, 2'b00, 3'b101, 3'b000, 32'h40000000, 32'h40000000, 32'h40000000, 5'd12,
              32'h12345678, 4'b0000, 32'h00000000, 5'b00000, 1'b1, 3'b101, 1};
    vt[5] = '{1'b1, 2'b11, 3'b100, 3'b001, 32'h40000000, 32'h40000000, 32'h3F800000, 5'd0,
              32'hC0A00000, 4'b1010, 32'hC0A00000, 5'b10010, 1'b0, 3'b100, 8};
    vt[6] = '{1'b0, 2'b00, 3'b111, 3'b100, 32'h40400000, 32'h40400000, 32'h00000000, 5'd1,
              32'h41100000, 4'b0000, 32'h41100000, 5'b00000, 1'b0, 3'b100, 8};
    vt[7] = '{1'b0, 2'b01, 3'b110, 3'b000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 5'd22,
              32'h12345678, 4'b0000, 32'h00000000, 5'b00000, 1'b1, 3'b110, 1};

    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // ---- table-driven single operations ----
    for (int i = 0; i < 8; i++) begin
      v = vt[i];
      model_res = v.mres;
      model_flg = v.mflg;
      frm = v.frm;
      set_req(v.port, 1'b1, v.op, v.rm, v.a, v.b, v.c, v.tag);
      wait_accept(v.port, $sformatf("v%0d", i));
      n = 1;
      chk($sformatf("v%0d_start", i), 64'(fma_start), 64'(!v.ill));
      if (!v.ill) begin
        chk($sformatf("v%0d_fma_rm", i), 64'(fma_rm), 64'(v.erm));
        chk($sformatf("v%0d_fma_op", i), 64'(fma_op), 64'(v.op));
        chk($sformatf("v%0d_fma_a", i),  64'(fma_a),  64'(v.a));
      end
      while (rsp_valid !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("v%0d_latency", i), 64'(n),           64'(v.elat));
      chk($sformatf("v%0d_result", i),  64'(rsp_result),  64'(v.eres));
      chk($sformatf("v%0d_flags", i),   64'(rsp_flags),   64'(v.eflg));
      chk($sformatf("v%0d_tag", i),     64'(rsp_tag),     64'(v.tag));
      chk($sformatf("v%0d_src", i),     64'(rsp_src),     64'(v.port));
      chk($sformatf("v%0d_illegal", i), 64'(rsp_illegal), 64'(v.ill));
      chk($sformatf("v%0d_timeout", i), 64'(rsp_timeout), 64'(0));
      if (!v.ill) chk($sformatf("v%0d_fma_c_held", i), 64'(fma_c), 64'(v.c));
      @(negedge clk);
    end

    // ---- round-robin with both ports requesting continuously ----
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    model_res = 32'h3F800000;
    model_flg = 4'h0;
    frm = 3'b000;
    set_req(1'b0, 1'b1, 2'b00, 3'b000, 32'h3F800000, 32'h3F800000, 32'h0, 5'd16);
    set_req(1'b1, 1'b1, 2'b00, 3'b000, 32'h3F800000, 32'h3F800000, 32'h0, 5'd17);
    k = 0;
    rk = 0;
    #1;
    for (int i = 0; i < 200 && k < 4; i++) begin
      if (rsp_valid === 1'b1 && rk < 4) begin rs[rk] = rsp_src; rk++; end
      if (req0_ready || req1_ready) begin
        chk("rr_onehot", 64'(req0_ready & req1_ready), 64'(0));
        g[k] = req1_ready;
        k++;
        if (k == 4) break;
      end
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("rr_count", 64'(k), 64'(4));
    chk("rr_g0", 64'(g[0]), 64'(0));
    chk("rr_g1", 64'(g[1]), 64'(1));
    chk("rr_g2", 64'(g[2]), 64'(0));
    chk("rr_g3", 64'(g[3]), 64'(1));
    chk("rr_rsp_count", 64'(rk), 64'(3));
    chk("rr_rsp_src0", 64'(rs[0]), 64'(0));
    chk("rr_rsp_src1", 64'(rs[1]), 64'(1));
    chk("rr_rsp_src2", 64'(rs[2]), 64'(0));
    for (int i = 0; i < 40 && rsp_valid !== 1'b1; i++) @(negedge clk);
    chk("rr_rsp_src3", 64'(rsp_src), 64'(1));
    @(negedge clk);

    // ---- lone requester on port 1 wins every time ----
    set_req(1'b1, 1'b1, 2'b00, 3'b000, 32'h3F800000, 32'h3F800000, 32'h0, 5'd18);
    k = 0;
    #1;
    for (int i = 0; i < 200 && k < 3; i++) begin
      if (req0_ready || req1_ready) begin
        g[k] = req1_ready;
        k++;
        if (k == 3) break;
      end
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    req1_valid = 1'b0;
    chk("solo_count", 64'(k), 64'(3));
    chk("solo_g0", 64'(g[0]), 64'(1));
    chk("solo_g1", 64'(g[1]), 64'(1));
    chk("solo_g2", 64'(g[2]), 64'(1));
    drain_rsp("solo");

    // ---- flush 3 cycles after start: no response, drain until done ----
    model_lat = 10;
    set_req(1'b0, 1'b1, 2'b00, 3'b000, 32'h40000000, 32'h40000000, 32'h0, 5'd5);
    wait_accept(1'b0, "flush");
    n = 1;
    while (n < 12) begin
      @(negedge clk);
      n++;
      if (n == 4) begin
        flush = 1'b1;
        req0_valid = 1'b1;
      end else if (n == 5) begin
        flush = 1'b0;
      end
      if (n >= 5 && n <= 11)
        chk($sformatf("flush_hold_n%0d", n), 64'({req0_ready, rsp_valid}), 64'(0));
    end
    chk("flush_ready_back", 64'(req0_ready), 64'(1));
    req0_valid = 1'b0;
    @(negedge clk);
    chk("flush_no_rsp", 64'(rsp_valid), 64'(0));
    model_lat = 6;

    // ---- timeout, then response stall with a spurious done ----
    model_en = 1'b0;
    rsp_ready = 1'b0;
    set_req(1'b1, 1'b1, 2'b01, 3'b000, 32'h40400000, 32'h3F800000, 32'h0, 5'd21);
    wait_accept(1'b1, "tmo");
    n = 1;
    chk("tmo_start", 64'(fma_start), 64'(1));
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (n == 15) chk("tmo_early", 64'(rsp_valid), 64'(0));
      if (n == 17) spur_cnt++;
      if (n >= 16) begin
        chk($sformatf("tmo_valid_n%0d", n),  64'(rsp_valid),   64'(1));
        chk($sformatf("tmo_result_n%0d", n), 64'(rsp_result),  64'(32'h7FC00000));
        chk($sformatf("tmo_flags_n%0d", n),  64'(rsp_flags),   64'(5'b10000));
        chk($sformatf("tmo_flag_n%0d", n),   64'(rsp_timeout), 64'(1));
      end
    end
    chk("tmo_tag",     64'(rsp_tag),     64'(21));
    chk("tmo_src",     64'(rsp_src),     64'(1));
    chk("tmo_illegal", 64'(rsp_illegal), 64'(0));
    chk("tmo_a_held",  64'(fma_a),       64'(32'h40400000));
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("tmo_handshake", 64'(rsp_valid), 64'(0));
    model_en = 1'b1;

    // ---- asynchronous reset in the middle of WAIT ----
    set_req(1'b0, 1'b1, 2'b10, 3'b011, 32'h40800000, 32'h40800000, 32'h40800000, 5'd13);
    wait_accept(1'b0, "arst");
    @(negedge clk);
    @(negedge clk);
    chk("arst_pre_a", 64'(fma_a), 64'(32'h40800000));
    reset_n = 1'b0;
    #1;
    check_reset_vals("arst");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    model_res = 32'h3F800000;
    set_req(1'b0, 1'b1, 2'b00, 3'b000, 32'h3F800000, 32'h3F800000, 32'h0, 5'd2);
    wait_accept(1'b0, "arst_after");
    chk("arst_after_start", 64'(fma_start), 64'(1));
    drain_rsp("arst_after");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire
